// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared types and constants for the out-of-order core.
//                Covers the ROB/PRF sizing, the completed-instruction struct,
//                the wakeup broadcast bus and the CDB requester indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    localparam int ROB_NUM_BITS  = 4;
    localparam int PHYS_REG_BITS = 6;

    // Completion data bus requesters
    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_ALU     = 0;
    localparam int CDB_MUL     = 1;
    localparam int CDB_BR      = 2;
    localparam int CDB_MEM     = 3;

    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              rs1_data;
        logic [31:0]              rs2_data;
        logic [PHYS_REG_BITS-1:0] rd_paddr;
        logic                     br_taken;
        logic [31:0]              br_target;
        logic                     mem_rd;
        logic                     mem_wr;
        logic [31:0]              mem_addr;
    } ooo_instr_t;

    typedef struct packed {
        logic                     valid;
        logic [PHYS_REG_BITS-1:0] rd_paddr;
        logic [31:0]              rd_data;
    } wb_bus_t;

    // Increment an index modulo n (works for non power-of-two n)
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_if
//  Description : Completion bus between the functional units (master side)
//                and the CDB arbiter (slave side), including the ROB status
//                push and the wakeup broadcast produced by the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_if
    import rv32i_types::*;
#(
    parameter int N = CDB_NUM_REQ
) ();

    logic [N-1:0]                        req_valid;
    logic [N-1:0][ROB_NUM_BITS-1:0]      req_rob_addr;
    ooo_instr_t [N-1:0]                  req_instr;
    logic [N-1:0][31:0]                  req_rd_data;
    logic [N-1:0]                        req_ready;

    logic                                push_status;
    logic [ROB_NUM_BITS-1:0]             rob_addr;
    ooo_instr_t                          wb_instr_struct;
    wb_bus_t                             wb_bus;

    // Arbiter side
    modport slave (
        input  req_valid, req_rob_addr, req_instr, req_rd_data,
        output req_ready, push_status, rob_addr, wb_instr_struct, wb_bus
    );

    // Functional unit / consumer side
    modport master (
        output req_valid, req_rob_addr, req_instr, req_rd_data,
        input  req_ready, push_status, rob_addr, wb_instr_struct, wb_bus
    );

endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Scans from ptr upward with
//                wrap-around and grants the first active request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rv32i_types::*;
#(
    parameter int N = CDB_NUM_REQ
) (
    input  logic [N-1:0]                          req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  ptr,
    output logic [N-1:0]                          gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  gnt_idx,
    output logic                                  any
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    int idx;

    // First requester at or after ptr, wrapping past N-1 back to 0
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                gnt_idx          = idx[PW-1:0];
                any              = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Shares the ROB completion port between the ALU, MUL, BR and
//                MEM units. Round-robin grant, one-stage registered status
//                push / wakeup broadcast, flush drops in-flight completions,
//                and a contention cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    cdb_if.slave        bus,
    output logic [31:0] contend_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               any;
    logic               take;
    logic               contended;

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // A flush suppresses the grant entirely; the units drop their own requests
    assign take          = any & ~flush;
    assign bus.req_ready = flush ? '0 : gnt;
    assign contended     = ($countones(bus.req_valid) >= 2) && !flush;

    // Output register and round-robin pointer; rst wins over any grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr              <= '0;
            bus.push_status     <= 1'b0;
            bus.rob_addr        <= '0;
            bus.wb_instr_struct <= '0;
            bus.wb_bus          <= '0;
        end else begin
            bus.push_status  <= take;
            bus.wb_bus.valid <= take;
            if (take) begin
                rr_ptr                <= PTR_W'(rr_wrap_inc(int'(gnt_idx), NUM_REQ));
                bus.rob_addr          <= bus.req_rob_addr[gnt_idx];
                bus.wb_instr_struct   <= bus.req_instr[gnt_idx];
                bus.wb_bus.rd_paddr   <= bus.req_instr[gnt_idx].rd_paddr;
                bus.wb_bus.rd_data    <= bus.req_rd_data[gnt_idx];
            end
        end
    end

    // Count cycles with two or more simultaneous requesters outside a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            contend_cnt <= '0;
        end else if (contended) begin
            contend_cnt <= contend_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Directed self-checking bench for cdb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] contend_cnt;

    int checks = 0;
    int errors = 0;

    cdb_if #(.N(4)) bus ();

    cdb_arbiter #(.NUM_REQ(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .contend_cnt (contend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic load_default_payload;
        for (int i = 0; i < 4; i++) begin
            bus.req_rob_addr[i]          = 4'(i + 8);
            bus.req_rd_data[i]           = 32'h1000_0000 + 32'(i);
            bus.req_instr[i]             = '0;
            bus.req_instr[i].rd_paddr    = 6'(i + 20);
            bus.req_instr[i].pc          = 32'(i * 4);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic granted;

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 4'b1111;
        load_default_payload();

        // Reset with every unit requesting
        tick();
        tick();
        chk("rst_push", 64'(bus.push_status), 64'd0);
        chk("rst_cnt", 64'(contend_cnt), 64'd0);
        chk("rst_rob", 64'(bus.rob_addr), 64'd0);
        chk("rst_wb", 64'(bus.wb_bus), 64'd0);
        chk("rst_instr_pc", 64'(bus.wb_instr_struct.pc), 64'd0);
        rst = 1'b0;
        settle();
        chk("rst_first_ready", 64'(bus.req_ready), 64'b0001);
        tick();
        chk("rst_first_push", 64'(bus.push_status), 64'd1);
        chk("rst_first_rob", 64'(bus.rob_addr), 64'd8);
        chk("rst_first_cnt", 64'(contend_cnt), 64'd1);

        // Single BR request with its own payload
        bus.req_valid = 4'b0000;
        do_reset();
        bus.req_rob_addr[CDB_BR]       = 4'd5;
        bus.req_rd_data[CDB_BR]        = 32'hDEAD_BEEF;
        bus.req_instr[CDB_BR].rd_paddr = 6'd12;
        bus.req_valid = 4'b0100;
        settle();
        chk("single_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        chk("single_push", 64'(bus.push_status), 64'd1);
        chk("single_rob", 64'(bus.rob_addr), 64'd5);
        chk("single_wb", 64'(bus.wb_bus), 64'({1'b1, 6'd12, 32'hDEAD_BEEF}));
        chk("single_instr_rd", 64'(bus.wb_instr_struct.rd_paddr), 64'd12);
        chk("single_ptr", 64'(dut.rr_ptr), 64'd3);
        chk("single_cnt", 64'(contend_cnt), 64'd0);

        // Wrap-around from rr_ptr = 3
        load_default_payload();
        bus.req_valid = 4'b0011;
        settle();
        chk("wrap_ready0", 64'(bus.req_ready), 64'b0001);
        tick();
        chk("wrap_rob0", 64'(bus.rob_addr), 64'd8);
        chk("wrap_ptr0", 64'(dut.rr_ptr), 64'd1);
        bus.req_valid = 4'b0010;
        settle();
        chk("wrap_ready1", 64'(bus.req_ready), 64'b0010);
        tick();
        chk("wrap_rob1", 64'(bus.rob_addr), 64'd9);
        chk("wrap_ptr1", 64'(dut.rr_ptr), 64'd2);
        chk("wrap_cnt", 64'(contend_cnt), 64'd1);

        // Full contention for 8 cycles
        bus.req_valid = 4'b0000;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("full_ready%0d", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("full_rob%0d", k), 64'(bus.rob_addr), 64'((k % 4) + 8));
            chk($sformatf("full_data%0d", k), 64'(bus.wb_bus.rd_data), 64'(32'h1000_0000 + (k % 4)));
        end
        chk("full_cnt", 64'(contend_cnt), 64'd8);

        // Flush: MEM granted in N, flush in N+1 with new requests
        bus.req_valid = 4'b1000;
        settle();
        chk("flush_mem_ready", 64'(bus.req_ready), 64'b1000);
        tick();
        chk("flush_ptr_pre", 64'(dut.rr_ptr), 64'd0);
        flush         = 1'b1;
        bus.req_valid = 4'b0011;
        settle();
        chk("flush_push_n1", 64'(bus.push_status), 64'd1);
        chk("flush_rob_n1", 64'(bus.rob_addr), 64'd11);
        chk("flush_ready_n1", 64'(bus.req_ready), 64'b0000);
        tick();
        chk("flush_push_n2", 64'(bus.push_status), 64'd0);
        chk("flush_wbv_n2", 64'(bus.wb_bus.valid), 64'd0);
        chk("flush_ptr_n2", 64'(dut.rr_ptr), 64'd0);
        chk("flush_cnt_n2", 64'(contend_cnt), 64'd8);
        chk("flush_rob_held", 64'(bus.rob_addr), 64'd11);
        flush         = 1'b0;
        bus.req_valid = 4'b0000;

        // Reset together with a request: grant never appears
        tick();
        bus.req_valid = 4'b0010;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b0000;
        chk("rstmid_push", 64'(bus.push_status), 64'd0);
        chk("rstmid_ptr", 64'(dut.rr_ptr), 64'd0);
        chk("rstmid_wb", 64'(bus.wb_bus), 64'd0);

        // Starvation bound: unit 3 held, units 0/1 random
        tick();
        granted = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (!granted) begin
                bus.req_valid = {1'b1, 1'b0, 2'($urandom)};
                settle();
                if (bus.req_ready[CDB_MEM]) granted = 1'b1;
                tick();
            end
        end
        chk("starve_mem_granted", 64'(granted), 64'd1);
        bus.req_valid = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single writeback/completion port of the reorder buffer (status push plus `wb_bus_t` broadcast) between the out-of-order functional units: ALU, multiplier, branch and memory. Each cycle it grants at most one completing unit using round-robin priority and drives the ROB status push and the reservation-station/regfile wakeup bus from a one-stage output register. On a branch-mispredict flush it drops all in-flight completions.

## Interface
- `NUM_REQ`, default 4: number of completing units. Index 0 = ALU, 1 = MUL, 2 = BR, 3 = MEM.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  mispredict flush, driven from `br_mispredict` at ROB head.
- `req_valid`  in  NUM_REQ  unit i holds a completed instruction.
- `req_rob_addr`  in  NUM_REQ x ROB_NUM_BITS  ROB slot of that instruction.
- `req_instr`  in  NUM_REQ x ooo_instr_t  completed instruction struct (rs data, branch, mem fields).
- `req_rd_data`  in  NUM_REQ x 32  result value.
- `req_ready`  out  NUM_REQ  one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `push_status`  out  1  ROB status write strobe.
- `rob_addr`  out  ROB_NUM_BITS  ROB slot to mark done.
- `wb_instr_struct`  out  ooo_instr_t  registered copy of the granted `req_instr`.
- `wb_bus`  out  wb_bus_t  wakeup broadcast: `valid`, `rd_paddr`, `rd_data`.
- `contend_cnt`  out  32  count of cycles in which two or more units requested and no flush was active.

## Operation
- **Arbitration.** A round-robin pointer `rr_ptr` (width clog2 NUM_REQ) selects the requester with highest priority. Grant goes to the first `req_valid[i]` scanning from `rr_ptr` upward, with wrap-around.
- **Ready.** `req_ready` is combinational from `req_valid` and `rr_ptr`. At most one bit is high. Ready is never high for a non-valid requester.
- **Pointer update.** After a grant to index g, `rr_ptr <= (g+1) mod NUM_REQ`. The pointer is unchanged if there is no grant.
- **Unit obligations.** A unit holds `req_valid` and its payload stable until it is granted. The arbiter does not buffer ungranted requests.
- **Output register.** On a grant, it captures `rob_addr`, `wb_instr_struct`, `wb_bus.rd_paddr = req_instr.rd_paddr` and `wb_bus.rd_data = req_rd_data`, and sets `push_status = wb_bus.valid = 1`. With no grant, both valids are 0 and the payload is held.
- **No backpressure.** The ROB always accepts a status push.
- **Flush.** While `flush` is high, `req_ready = 0` and the output valids are cleared next cycle. A grant registered in the flush cycle is discarded. `rr_ptr` is not changed. Units are responsible for dropping their own pending requests.
- **Contention counter.** `contend_cnt` increments by 1 when popcount(`req_valid`) >= 2 and `flush` is 0. It wraps at 2^32.

## Timing
- **Latency.** Request to `push_status`/`wb_bus.valid` is 1 cycle: grant in cycle N, outputs valid in cycle N+1.
- **Throughput.** One completion per cycle.
- **Fairness.** A continuously asserted request is granted within NUM_REQ cycles.
- **Reset values.** `push_status = 0`, `wb_bus = '0`, `rob_addr = '0`, `wb_instr_struct = '0`, `rr_ptr = 0`, `contend_cnt = 0`. `req_ready` follows `req_valid` with `rr_ptr = 0` in the cycle after reset.
- **Reset vs flush.** `rst` dominates `flush`.
- **Reset mid-operation.** A grant issued in the same cycle as `rst` does not appear on the outputs.
- **Single requester.** A lone requester is granted immediately regardless of `rr_ptr`.
- **Flush and new request.** `flush` and new `req_valid` in the same cycle: no grant, and no increment of `contend_cnt`.

## Structure
- Package `rv32i_types` holds:
  - `CDB_NUM_REQ` (=4) and the requester index constants `CDB_ALU`, `CDB_MUL`, `CDB_BR`, `CDB_MEM`.
  - `wb_bus_t`, with fields `valid`, `rd_paddr[PHYS_REG_BITS]`, `rd_data[32]`.
  - Reuse of existing `ooo_instr_t` and `ROB_NUM_BITS`.
- Sub-module `rr_arbiter` (parameter `N`): inputs `req[N]` and `ptr`; outputs one-hot `gnt[N]`, `gnt_idx` and `any`. It is combinational only. `cdb_arbiter` owns the pointer, the output register, the flush handling and the counter.

## Test plan
- **Reset.** Assert `rst` with all `req_valid = 1111` → next cycle `push_status = 0`, `contend_cnt = 0`. The first post-reset grant is `req_ready = 0001`.
- **Single request.** `req_valid = 0100`, rob_addr 5, rd_data 0xDEADBEEF, rd_paddr 12 → `req_ready = 0100` that cycle. Next cycle `push_status = 1`, `rob_addr = 5`, `wb_bus = {1, 12, 0xDEADBEEF}`, and `rr_ptr = 3`.
- **Full contention.** Hold `req_valid = 1111` for 8 cycles, each unit dropping valid only when granted and reasserting after → grants are 0,1,2,3,0,1,2,3, and `contend_cnt = 8`.
- **Wrap-around.** Set `rr_ptr = 3` (after a grant to 2); requests `0011` → grant to 0, then 1.
- **Flush.** Grant to the MEM unit in cycle N, `flush = 1` in cycle N+1 with `req_valid = 0011` → `push_status = 1` in cycle N+1 (the MEM result). In cycle N+2, `push_status = 0`, `req_ready` was 0 in N+1, and `rr_ptr` is unchanged.
- **Starvation bound.** Units 0 and 1 toggle requests randomly while unit 3 holds a request → unit 3 is granted within 4 cycles of asserting.
